// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word/dword accesses to an 8-byte-wide data memory,
// with read-modify-write for sub-word stores. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  // state  | meaning
  // IDLE   | ready for a new request
  // LOAD   | memory read, extended data registered into resp_rdata
  // RMW_RD | sub-word store: read old dword, merge new bytes into buffer
  // WR     | memory write of merge buffer
  // RESP   | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WR, RESP} state_t;

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES) - 64'd8;

  state_t      state_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [63:0] buf_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;
  logic        req_err;
  logic        mem_active;

  function automatic logic [63:0] extend_load(input logic [63:0] d, input logic [1:0] sz,
                                              input logic uns);
    case (sz)
      2'b00:   return uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      2'b01:   return uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'b10:   return uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [63:0] merge_store(input logic [63:0] old, input logic [63:0] w,
                                              input logic [1:0] sz);
    case (sz)
      2'b00:   return {old[63:8],  w[7:0]};
      2'b01:   return {old[63:16], w[15:0]};
      2'b10:   return {old[63:32], w[31:0]};
      default: return w;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end
  assign req_err = (req_addr > MAX_ADDR) || misaligned;
`else
  assign req_err = (req_addr > MAX_ADDR);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      buf_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (!req_write) begin
              state_q <= LOAD;
            end else if (req_size == 2'b11) begin
              buf_q   <= req_wdata;
              state_q <= WR;
            end else begin
              state_q <= RMW_RD;
            end
          end
        end
        LOAD: begin
          resp_rdata_q <= extend_load(Read_Data, size_q, unsigned_q);
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RMW_RD: begin
          buf_q   <= merge_store(Read_Data, wdata_q, size_q);
          state_q <= WR;
        end
        WR: begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory controls decode straight from the state register, so reset kills them at once.
  assign mem_active = (state_q == LOAD) || (state_q == RMW_RD) || (state_q == WR);
  assign req_ready  = (state_q == IDLE);
  assign MemRead    = (state_q == LOAD) || (state_q == RMW_RD);
  assign MemWrite   = (state_q == WR);
  assign Mem_Addr   = mem_active ? addr_q : 64'd0;
  assign Write_Data = (state_q == WR) ? buf_q : 64'd0;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
